// File: rtl/nib_tx_if.sv
// Handshake and serial-line bundle for the nibble transmitter.
// The master side supplies the load, data and bit strobe; the slave side returns line and status.
interface nib_tx_if;
   logic       CE;
   logic       LD;
   logic [3:0] D;
   logic       TXD;
   logic       RDY;
   logic       BUSY;

   modport master (
      output CE,
      output LD,
      output D,
      input  TXD,
      input  RDY,
      input  BUSY
   );

   modport slave (
      input  CE,
      input  LD,
      input  D,
      output TXD,
      output RDY,
      output BUSY
   );
endinterface

// File: rtl/nib_tx.sv
// Serial nibble transmitter: start bit, four data bits LSB first, optional parity, stop bit.
// Each bit lasts DIV strobes of CE; TXD is registered and idles high.
module nib_tx #(
   parameter int unsigned DIV     = 1,
   parameter int unsigned PAR_EN  = 1,
   parameter int unsigned PAR_ODD = 0
) (
   input logic        CK,
   input logic        CLR,
   nib_tx_if.slave    bus
);

   localparam int unsigned TickW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop
   } state_e;

   state_e           state_q, state_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             txd_q, txd_d;
   logic             accept;
   logic             bit_end;

   // Acceptance ignores CE; the strobe only matters once the frame has started.
   assign accept  = (state_q == StIdle) && bus.LD;
   assign bit_end = (state_q != StIdle) && bus.CE && (tick_q == TickLast);

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept)  state_d = StStart;
         StStart: if (bit_end) state_d = StData;
         StData: begin
            if (bit_end && (idx_q == 2'd3)) begin
               state_d = (PAR_EN != 0) ? StPar : StStop;
            end
         end
         StPar:   if (bit_end) state_d = StStop;
         StStop:  if (bit_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tick_d  = tick_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      if (accept) begin
         shift_d = bus.D;
         par_d   = (^bus.D) ^ (PAR_ODD != 0);
         idx_d   = 2'd0;
         tick_d  = '0;
      end else if ((state_q != StIdle) && bus.CE) begin
         if (bit_end) begin
            tick_d = '0;
            if ((state_q == StData) && (idx_q != 2'd3)) begin
               shift_d = {1'b0, shift_q[3:1]};
               idx_d   = idx_q + 2'd1;
            end
         end else begin
            tick_d = tick_q + TickW'(1);
         end
      end
   end

   // Line level is decoded from the state being entered so TXD changes with the state.
   always_comb begin
      txd_d = 1'b1;
      unique case (state_d)
         StIdle:  txd_d = 1'b1;
         StStart: txd_d = 1'b0;
         StData:  txd_d = shift_d[0];
         StPar:   txd_d = par_d;
         StStop:  txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         tick_q  <= '0;
         idx_q   <= 2'd0;
         shift_q <= 4'd0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
      end
   end

   assign bus.TXD  = txd_q;
   assign bus.RDY  = (state_q == StIdle);
   assign bus.BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_nib_tx.sv
// Bench for nib_tx: four configurations share one stimulus stream and are each checked
// against a frame-level model (bit list, strobes per bit).
module tb_nib_tx;

   localparam int N = 4;

   logic       ck = 1'b0;
   logic       clr;
   logic       ce;
   logic       ld;
   logic [3:0] d;

   int total = 0;
   int bad   = 0;

   nib_tx_if if0 ();
   nib_tx_if if1 ();
   nib_tx_if if2 ();
   nib_tx_if if3 ();

   assign if0.CE = ce;  assign if0.LD = ld;  assign if0.D = d;
   assign if1.CE = ce;  assign if1.LD = ld;  assign if1.D = d;
   assign if2.CE = ce;  assign if2.LD = ld;  assign if2.D = d;
   assign if3.CE = ce;  assign if3.LD = ld;  assign if3.D = d;

   nib_tx #(.DIV(1), .PAR_EN(1), .PAR_ODD(0)) u_even  (.CK(ck), .CLR(clr), .bus(if0));
   nib_tx #(.DIV(1), .PAR_EN(1), .PAR_ODD(1)) u_odd   (.CK(ck), .CLR(clr), .bus(if1));
   nib_tx #(.DIV(1), .PAR_EN(0), .PAR_ODD(0)) u_nopar (.CK(ck), .CLR(clr), .bus(if2));
   nib_tx #(.DIV(4), .PAR_EN(1), .PAR_ODD(0)) u_div4  (.CK(ck), .CLR(clr), .bus(if3));

   logic [N-1:0] txd, rdy, busy;
   assign txd  = {if3.TXD, if2.TXD, if1.TXD, if0.TXD};
   assign rdy  = {if3.RDY, if2.RDY, if1.RDY, if0.RDY};
   assign busy = {if3.BUSY, if2.BUSY, if1.BUSY, if0.BUSY};

   always #5 ck = ~ck;

   // Frame model: list of line levels, each held for DIV strobes after the accepting edge.
   int   div_m [N] = '{1, 1, 1, 4};
   int   pen_m [N] = '{1, 1, 0, 1};
   int   podd_m[N] = '{0, 1, 0, 0};
   bit   busy_m[N];
   logic [7:0] bits_m[N];
   int   len_m[N];
   int   b_m[N];
   int   s_m[N];

   function automatic logic exp_txd(int i);
      return busy_m[i] ? bits_m[i][b_m[i]] : 1'b1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         busy_m[i] = 1'b0;
         b_m[i]    = 0;
         s_m[i]    = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         if (!busy_m[i]) begin
            if (ld) begin
               busy_m[i]      = 1'b1;
               b_m[i]         = 0;
               s_m[i]         = 0;
               len_m[i]       = (pen_m[i] != 0) ? 7 : 6;
               bits_m[i]      = 8'hFF;
               bits_m[i][0]   = 1'b0;
               bits_m[i][4:1] = d;
               if (pen_m[i] != 0) bits_m[i][5] = (^d) ^ (podd_m[i] != 0);
            end
         end else if (ce) begin
            s_m[i]++;
            if (s_m[i] == div_m[i]) begin
               s_m[i] = 0;
               b_m[i]++;
               if (b_m[i] == len_m[i]) busy_m[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge ck);
      if (clr) model_clear();
      else model_edge();
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      ld  = 1'b0;
      ce  = 1'b0;
      model_clear();
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      ce = 1'b0; ld = 1'b0; d = 4'h0; clr = 1'b0;
      #1 clr = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         total++;
         if (txd[i] !== 1'b1 || rdy[i] !== 1'b1 || busy[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state inst=%0d txd=%b rdy=%b busy=%b want 1 1 0",
                     i, txd[i], rdy[i], busy[i]);
         end
      end
      model_clear();
      ld = 1'b1; ce = 1'b1; d = 4'h5;
      tick();
      for (int i = 0; i < N; i++) begin
         total++;
         if (busy[i] !== 1'b0 || txd[i] !== 1'b1) begin
            bad++;
            $display("FAIL reset_holds inst=%0d busy=%b txd=%b want 0 1", i, busy[i], txd[i]);
         end
      end
      clr = 1'b0;
      tick();
      ld = 1'b0;
      for (int i = 0; i < N; i++) begin
         total++;
         if (busy[i] !== 1'b1 || txd[i] !== 1'b0 || busy_m[i] !== 1'b1) begin
            bad++;
            $display("FAIL first_edge_load inst=%0d busy=%b txd=%b want 1 0", i, busy[i], txd[i]);
         end
      end
   endtask

   task automatic run_frame(input logic [3:0] val, input int inst, input logic [6:0] exp_seq,
                            input int len, input string name);
      do_reset();
      d = val; ld = 1'b1; ce = 1'b1;
      for (int k = 0; k <= len; k++) begin
         tick();
         ld = 1'b0;
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || rdy[i] !== !busy_m[i] || busy[i] !== busy_m[i]) begin
               bad++;
               $display("FAIL %s_model inst=%0d k=%0d txd=%b rdy=%b busy=%b want txd=%b busy=%b",
                        name, i, k, txd[i], rdy[i], busy[i], exp_txd(i), busy_m[i]);
            end
         end
         total++;
         if (k < len) begin
            if (txd[inst] !== exp_seq[k]) begin
               bad++;
               $display("FAIL %s_bit k=%0d txd=%b want %b", name, k, txd[inst], exp_seq[k]);
            end
         end else if (rdy[inst] !== 1'b1) begin
            bad++;
            $display("FAIL %s_rdy_after rdy=%b want 1", name, rdy[inst]);
         end
      end
   endtask

   task automatic test_frames();
      run_frame(4'b1011, 0, 7'b1110110, 7, "even_1011");
      run_frame(4'b0000, 1, 7'b1100000, 7, "odd_0000");
      run_frame(4'b0101, 2, 7'b0101010, 6, "nopar_0101");
   endtask

   task automatic test_div();
      int busy_cnt;
      int first_high;
      do_reset();
      d = 4'hF; ld = 1'b1; ce = 1'b0;
      tick();
      ld = 1'b0;
      busy_cnt   = busy[3] ? 1 : 0;
      first_high = (txd[3] === 1'b1) ? 0 : -1;
      for (int j = 1; j < 100; j++) begin
         ce = ((j % 3) == 0);
         tick();
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || busy[i] !== busy_m[i]) begin
               bad++;
               $display("FAIL div_model inst=%0d j=%0d txd=%b busy=%b want txd=%b busy=%b",
                        i, j, txd[i], busy[i], exp_txd(i), busy_m[i]);
            end
         end
         if (busy[3] === 1'b1) busy_cnt++;
         if (first_high < 0 && txd[3] === 1'b1) first_high = j;
      end
      total++;
      if (busy_cnt != 84) begin
         bad++;
         $display("FAIL div_frame_len got=%0d want 84", busy_cnt);
      end
      total++;
      if (first_high != 12) begin
         bad++;
         $display("FAIL div_start_len got=%0d want 12", first_high);
      end
   endtask

   task automatic test_ld_ignored();
      logic [6:0] seq;
      int lows_after;
      do_reset();
      d = 4'h3; ld = 1'b1; ce = 1'b1;
      seq = '0;
      lows_after = 0;
      for (int k = 0; k < 14; k++) begin
         tick();
         ld = (k >= 2 && k <= 4);
         d  = ld ? 4'hF : 4'h3;
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || busy[i] !== busy_m[i]) begin
               bad++;
               $display("FAIL ld_ignored_model inst=%0d k=%0d txd=%b busy=%b want txd=%b busy=%b",
                        i, k, txd[i], busy[i], exp_txd(i), busy_m[i]);
            end
         end
         if (k < 7) seq[k] = txd[0];
         else if (txd[0] !== 1'b1 || rdy[0] !== 1'b1) lows_after++;
      end
      total++;
      if (seq !== 7'b1000110) begin
         bad++;
         $display("FAIL ld_ignored_frame got=%b want %b", seq, 7'b1000110);
      end
      total++;
      if (lows_after != 0) begin
         bad++;
         $display("FAIL ld_ignored_second_frame cycles=%0d want 0", lows_after);
      end
   endtask

   task automatic test_clr_mid();
      logic [6:0] seq;
      do_reset();
      d = 4'($urandom); ld = 1'b1; ce = 1'b1;
      tick();
      ld = 1'b0;
      tick();
      tick();
      #2 clr = 1'b1;
      model_clear();
      #1;
      for (int i = 0; i < N; i++) begin
         total++;
         if (txd[i] !== 1'b1 || rdy[i] !== 1'b1 || busy[i] !== 1'b0) begin
            bad++;
            $display("FAIL clr_async inst=%0d txd=%b rdy=%b busy=%b want 1 1 0",
                     i, txd[i], rdy[i], busy[i]);
         end
      end
      tick();
      clr = 1'b0;
      d = 4'hA; ld = 1'b1;
      seq = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         ld = 1'b0;
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || busy[i] !== busy_m[i]) begin
               bad++;
               $display("FAIL clr_model inst=%0d k=%0d txd=%b busy=%b want txd=%b busy=%b",
                        i, k, txd[i], busy[i], exp_txd(i), busy_m[i]);
            end
         end
         if (k < 7) seq[k] = txd[0];
      end
      total++;
      if (seq !== 7'b1010100) begin
         bad++;
         $display("FAIL clr_next_frame got=%b want %b", seq, 7'b1010100);
      end
   endtask

   task automatic test_ce_hold();
      logic p;
      do_reset();
      d = 4'($urandom); ld = 1'b1; ce = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         ld = 1'b0;
      end
      p = (^d);
      total++;
      if (txd[0] !== p) begin
         bad++;
         $display("FAIL ce_hold_par_bit txd=%b want %b", txd[0], p);
      end
      ce = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || busy[i] !== busy_m[i]) begin
               bad++;
               $display("FAIL ce_hold inst=%0d k=%0d txd=%b busy=%b want txd=%b busy=%b",
                        i, k, txd[i], busy[i], exp_txd(i), busy_m[i]);
            end
         end
      end
      ce = 1'b1;
      tick();
      total++;
      if (txd[0] !== 1'b1 || busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL ce_resume_stop txd=%b busy=%b want 1 1", txd[0], busy[0]);
      end
      tick();
      total++;
      if (rdy[0] !== 1'b1) begin
         bad++;
         $display("FAIL ce_resume_idle rdy=%b want 1", rdy[0]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ld = 1'b1; ce = 1'b1;
      for (int k = 0; k < 40; k++) begin
         d = 4'($urandom);
         tick();
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || rdy[i] !== !busy_m[i]) begin
               bad++;
               $display("FAIL back_to_back inst=%0d k=%0d txd=%b rdy=%b want txd=%b rdy=%b",
                        i, k, txd[i], rdy[i], exp_txd(i), !busy_m[i]);
            end
         end
      end
      ld = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 800; k++) begin
         ld = ($urandom_range(0, 3) == 0);
         ce = ($urandom_range(0, 2) != 0);
         d  = 4'($urandom);
         tick();
         for (int i = 0; i < N; i++) begin
            total++;
            if (txd[i] !== exp_txd(i) || rdy[i] !== !busy_m[i] || busy[i] !== busy_m[i]) begin
               bad++;
               $display("FAIL random inst=%0d k=%0d txd=%b rdy=%b busy=%b want txd=%b busy=%b",
                        i, k, txd[i], rdy[i], busy[i], exp_txd(i), busy_m[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_div();
      test_ld_ignored();
      test_clr_mid();
      test_ce_hold();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nib_tx.md
NIB_TX -- requirements
Module: nib_tx

Interface
REQ-001 SHALL have parameter DIV, default 1: number of CE strobes per serial bit period; legal range 1..16.
REQ-002 SHALL have parameter PAR_EN, default 1: 1 inserts a parity bit after the data bits, 0 omits it.
REQ-003 SHALL have parameter PAR_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port CK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port CLR, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port CE, input, 1 bit: bit-rate strobe, sampled on CK.
REQ-007 SHALL have port LD, input, 1 bit: load request for one nibble.
REQ-008 SHALL have port D, input, 4 bits: the nibble to transmit.
REQ-009 SHALL have port TXD, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port RDY, output, 1 bit: high when a load will be accepted.
REQ-011 SHALL have port BUSY, output, 1 bit: high while a frame is in progress; it is the complement of RDY.

Function
REQ-012 SHALL implement the states IDLE, START, DATA, PAR and STOP.
REQ-013 SHALL assert RDY only in IDLE.
REQ-014 SHALL accept a load on a CK edge where LD=1 and RDY=1, regardless of CE.
REQ-015 SHALL, on acceptance, capture D into an internal shift register and enter START on that same edge.
REQ-016 SHALL ignore LD and any change on D while BUSY=1, leaving the frame unaffected.
REQ-017 SHALL drive TXD as a registered output per state: IDLE=1, START=0, DATA=current LSB of the shift register, PAR=parity bit, STOP=1.
REQ-018 SHALL transmit data bits LSB first: D[0], D[1], D[2], D[3].
REQ-019 SHALL compute the parity bit as XOR of the captured nibble, inverted when PAR_ODD=1.
REQ-020 SHALL keep a tick counter, reset to 0 on each state entry, that increments on CK edges with CE=1.
REQ-021 SHALL end a bit period on the CK edge where CE=1 and the tick counter equals DIV-1; CK edges with CE=0 do not advance the counter.
REQ-022 SHALL, at each bit-period end, make these transitions:
  - START -> DATA with bit index 0.
  - DATA with index < 3: shift right and increment the index.
  - DATA with index 3: go to PAR when PAR_EN=1, otherwise to STOP.
  - PAR -> STOP.
  - STOP -> IDLE.
REQ-023 SHALL have a frame length of 7 bit periods with parity and 6 without; with DIV=1 and CE held at 1, TXD is low for exactly 1 CK cycle for the start bit.
REQ-024 SHALL NOT accept a load in the final STOP cycle; RDY rises the cycle after STOP ends, and the earliest new START follows 1 CK cycle after that.
REQ-025 SHALL treat CE held at 0 mid-frame as freezing the state and TXD indefinitely, with no data corruption.
REQ-026 SHALL make LD and CE both 1 on the acceptance edge count only as acceptance, with the start-bit tick count beginning on the next edge.

Reset
REQ-027 SHALL, while CLR=1, immediately force state IDLE, TXD=1, RDY=1, BUSY=0, and the tick counter, bit index and shift register to 0.
REQ-028 SHALL abort a frame when CLR is asserted mid-frame: TXD returns high without completing the frame, and no load is pending after CLR is released.
REQ-029 SHALL accept LD on the first CK edge after CLR is deasserted.

Verification
REQ-030 With DIV=1, PAR_EN=1, PAR_ODD=0, CE=1 and D=4'b1011 loaded, TXD SHALL be 0,1,1,0,1,1,1 over 7 cycles, then RDY=1.
REQ-031 With PAR_ODD=1 and D=4'b0000, the parity bit SHALL be 1; with PAR_EN=0 and D=4'b0101, TXD SHALL be 0,1,0,1,0,1 (6 bits).
REQ-032 With DIV=4 and CE pulsing every 3rd CK, each bit SHALL last 12 CK cycles and the frame 84 CK cycles.
REQ-033 Applying LD with D=4'hF during the DATA state of a frame carrying D=4'h3 SHALL leave the frame unchanged and produce no second frame.
REQ-034 Asserting CLR mid-DATA, releasing it, and then loading 4'hA SHALL make TXD go high asynchronously on CLR, and the next frame SHALL be correct: 0,0,1,0,1,0,1.
REQ-035 Holding CE=0 for 20 cycles in PAR SHALL hold TXD constant; resuming CE SHALL complete STOP normally.
